// File: rtl/tile_cfg_pkg.sv
// Shared definitions for the tile configuration memory controller.
//   COMMIT_WRITE_THROUGH / COMMIT_DOUBLE_BUF : values for the CommitMode parameter
//   used_frames() : number of frames needed to hold a tile's config bits
//   cnt_width()   : width of the saturating frame-write counter
package tile_cfg_pkg;

    localparam int COMMIT_WRITE_THROUGH = 0;
    localparam int COMMIT_DOUBLE_BUF    = 1;

    function automatic int used_frames(input int no_config_bits, input int frame_bits);
        return (no_config_bits + frame_bits - 1) / frame_bits;
    endfunction

    function automatic int cnt_width(input int max_frames);
        return $clog2(max_frames + 1);
    endfunction

endpackage

// File: rtl/tile_cfg_frame_reg.sv
// One configuration frame: strobe edge detector, staging register, optional
// active register (double-buffered mode) and the frame's loaded flag.
// Ports:
//   CLK, resetn  : clock, async active-low reset
//   strobe       : this frame's strobe line
//   frame_data   : payload bits kept for this frame (ValidBits wide)
//   commit       : copy staging to active (double-buffered mode only)
//   write        : strobe rising edge, i.e. this frame is written this cycle
//   active       : bits currently driven to the tile
//   loaded       : frame written since reset / last commit
module tile_cfg_frame_reg
    import tile_cfg_pkg::*;
#(
    parameter int ValidBits  = 32,
    parameter int CommitMode = COMMIT_WRITE_THROUGH
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 strobe,
    input  logic [ValidBits-1:0] frame_data,
    input  logic                 commit,
    output logic                 write,
    output logic [ValidBits-1:0] active,
    output logic                 loaded
);

    logic                 strobe_q;
    logic [ValidBits-1:0] staging;

    assign write = strobe & ~strobe_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            strobe_q <= 1'b0;
            staging  <= '0;
        end else begin
            strobe_q <= strobe;
            if (write) staging <= frame_data;
        end
    end

    generate
        if (CommitMode == COMMIT_DOUBLE_BUF) begin : g_dbuf
            logic [ValidBits-1:0] active_q;

            // Commit samples staging before this cycle's write lands, and a
            // coinciding write re-marks its own frame in the freshly cleared mask.
            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn) begin
                    active_q <= '0;
                    loaded   <= 1'b0;
                end else if (commit) begin
                    active_q <= staging;
                    loaded   <= write;
                end else if (write) begin
                    loaded   <= 1'b1;
                end
            end

            assign active = active_q;
        end else begin : g_wt
            logic unused_commit;
            assign unused_commit = commit;

            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn)    loaded <= 1'b0;
                else if (write) loaded <= 1'b1;
            end

            assign active = staging;
        end
    endgenerate

endmodule

// File: rtl/tile_cfg_mem_ctrl.sv
// Clocked per-tile configuration memory. Frames are captured on strobe rising
// edges and drive ConfigBits either directly (write-through) or on Commit.
// Optional feature macro: TILE_CFG_READBACK_EN adds registered readback of the
// active frames.
// Ports:
//   CLK, resetn    : clock, async active-low reset
//   FrameData      : frame payload, broadcast to every frame edging this cycle
//   FrameStrobe    : per-frame write strobes (edge triggered)
//   Commit         : staging -> active copy (double-buffered mode only)
//   ConfigBits(_N) : active configuration and its inverse
//   FramesLoaded   : every used frame written since reset / last commit
//   WriteCount     : saturating count of cycles with at least one frame write
//   StrobeErr      : sticky, strobe edge on a frame beyond the used range
//   ReadbackSel/ReadbackData : (TILE_CFG_READBACK_EN) 1-cycle read of active frame
module tile_cfg_mem_ctrl
    import tile_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 64,
    parameter int CommitMode      = COMMIT_WRITE_THROUGH
) (
    input  logic                                          CLK,
    input  logic                                          resetn,
    input  logic [FrameBitsPerRow-1:0]                    FrameData,
    input  logic [MaxFramesPerCol-1:0]                    FrameStrobe,
    input  logic                                          Commit,
    output logic [((NoConfigBits > 0) ? NoConfigBits : 1)-1:0] ConfigBits,
    output logic [((NoConfigBits > 0) ? NoConfigBits : 1)-1:0] ConfigBits_N,
    output logic                                          FramesLoaded,
    output logic [cnt_width(MaxFramesPerCol)-1:0]         WriteCount,
    output logic                                          StrobeErr
`ifdef TILE_CFG_READBACK_EN
    ,
    input  logic [$clog2(MaxFramesPerCol)-1:0]            ReadbackSel,
    output logic [FrameBitsPerRow-1:0]                    ReadbackData
`endif
);

    localparam int USED   = used_frames(NoConfigBits, FrameBitsPerRow);
    localparam int USED_W = (USED > 0) ? USED : 1;
    localparam int CFG_W  = (NoConfigBits > 0) ? NoConfigBits : 1;
    localparam int CNT_W  = cnt_width(MaxFramesPerCol);
    localparam int SPARE  = MaxFramesPerCol - USED;

    logic              commit_eff;
    logic [USED_W-1:0] write_vec;
    logic [USED_W-1:0] loaded_vec;
    logic [CFG_W-1:0]  active_bits;
    logic              any_write;
    logic              spare_edge;
    logic [CNT_W-1:0]  cnt;
    logic              err;

    assign commit_eff = (CommitMode == COMMIT_DOUBLE_BUF) && Commit;

    generate
        if (USED == 0) begin : g_no_frames
            logic unused_data;
            assign unused_data = ^FrameData;
            assign write_vec   = '0;
            assign loaded_vec  = '1;
            assign active_bits = '0;
        end else begin : g_frames
            for (genvar f = 0; f < USED; f++) begin : g_frame
                // The last frame keeps only the bits that exist in the tile.
                localparam int VB = ((NoConfigBits - f * FrameBitsPerRow) >= FrameBitsPerRow)
                                    ? FrameBitsPerRow : (NoConfigBits - f * FrameBitsPerRow);
                tile_cfg_frame_reg #(
                    .ValidBits  (VB),
                    .CommitMode (CommitMode)
                ) u_frame (
                    .CLK        (CLK),
                    .resetn     (resetn),
                    .strobe     (FrameStrobe[f]),
                    .frame_data (FrameData[VB-1:0]),
                    .commit     (commit_eff),
                    .write      (write_vec[f]),
                    .active     (active_bits[f*FrameBitsPerRow +: VB]),
                    .loaded     (loaded_vec[f])
                );
            end
        end

        if (SPARE > 0) begin : g_spare
            logic [SPARE-1:0] spare_q;
            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn) spare_q <= '0;
                else         spare_q <= FrameStrobe[MaxFramesPerCol-1:USED];
            end
            assign spare_edge = |(FrameStrobe[MaxFramesPerCol-1:USED] & ~spare_q);
        end else begin : g_no_spare
            assign spare_edge = 1'b0;
        end
    endgenerate

    assign any_write = |write_vec;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= err | spare_edge;
            if (commit_eff)
                cnt <= any_write ? CNT_W'(1) : '0;
            else if (any_write && (cnt != '1))
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign ConfigBits   = active_bits;
    assign ConfigBits_N = ~active_bits;
    assign FramesLoaded = &loaded_vec;
    assign WriteCount   = cnt;
    assign StrobeErr    = err;

`ifdef TILE_CFG_READBACK_EN
    localparam int SEL_W = $clog2(MaxFramesPerCol);

    logic [FrameBitsPerRow-1:0] rb_word [2**SEL_W];

    generate
        for (genvar r = 0; r < 2**SEL_W; r++) begin : g_rb
            if (r < USED) begin : g_used
                localparam int VB = ((NoConfigBits - r * FrameBitsPerRow) >= FrameBitsPerRow)
                                    ? FrameBitsPerRow : (NoConfigBits - r * FrameBitsPerRow);
                assign rb_word[r] = FrameBitsPerRow'(active_bits[r*FrameBitsPerRow +: VB]);
            end else begin : g_unused
                assign rb_word[r] = '0;
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) ReadbackData <= '0;
        else         ReadbackData <= rb_word[ReadbackSel];
    end
`endif

endmodule
